apb_master: RTL and testbench

- APB requester that drives the `apb_ram`-style completer interface.
- Accepts single read/write commands on a simple valid/ready command port.
- Runs the APB SETUP → ACCESS sequence, waits for `pready` with a bounded wait-state counter, and returns read data and error status as a one-cycle response pulse.
- Sits between a test/CPU-side command source and any APB slave on the bus.

---
 rtl/apb_master_if.sv | 51 +++++
 rtl/apb_master.sv | 125 ++++++++++++
 tb/tb_apb_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
// Groups the command/response port and the APB bus seen by apb_master.
//   cmd_*   : valid/ready command channel from the requesting side
//   rsp_*   : one-cycle response pulse back to the requesting side
//   p*      : APB requester signals (psel/penable/pwrite/paddr/pwdata out,
//             prdata/pready/pslverr in)
// Modports:
//   master : view taken by apb_master
//   slave  : view taken by the environment (command source + APB completer)
// ---------------------------------------------------------------------------
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// Single-transfer APB requester. Accepts one read/write command at a time,
// runs SETUP -> ACCESS on the APB bus, waits for pready with a bounded
// wait-state counter and returns a one-cycle response pulse.
// Ports:
//   pclk     : clock, rising edge
//   presetn  : asynchronous active-low reset
//   bus      : apb_master_if.master (command, response and APB signals)
// All outputs are registered except cmd_ready, which is (state == IDLE).
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_master_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_slverr_r;
    logic              rsp_timeout_r;

    assign bus.cmd_ready   = (state_r == ST_IDLE);
    assign bus.psel        = psel_r;
    assign bus.penable     = penable_r;
    assign bus.pwrite      = pwrite_r;
    assign bus.paddr       = paddr_r;
    assign bus.pwdata      = pwdata_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_slverr  = rsp_slverr_r;
    assign bus.rsp_timeout = rsp_timeout_r;

    // Transfer FSM: sequences the APB phases and produces the response pulse.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= {CNT_W{1'b0}};
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            pwdata_r      <= {DATA_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            // Response flags are pulses; rsp_rdata holds until overwritten.
            rsp_valid_r   <= 1'b0;
            rsp_slverr_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    penable_r <= 1'b0;
                    if (bus.cmd_valid) begin
                        // pwdata is captured for reads too; it is unused on the bus.
                        paddr_r  <= bus.cmd_addr;
                        pwrite_r <= bus.cmd_write;
                        pwdata_r <= bus.cmd_wdata;
                        psel_r   <= 1'b1;
                        state_r  <= ST_SETUP;
                    end else begin
                        psel_r   <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    penable_r  <= 1'b1;
                    wait_cnt_r <= {CNT_W{1'b0}};
                    state_r    <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // Completion is checked first so a pready on the last
                    // permitted cycle still ends the transfer normally.
                    if (bus.pready) begin
                        rsp_valid_r  <= 1'b1;
                        rsp_rdata_r  <= pwrite_r ? {DATA_W{1'b0}} : bus.prdata;
                        rsp_slverr_r <= bus.pslverr;
                        psel_r       <= 1'b0;
                        penable_r    <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_W{1'b0}};
                        rsp_slverr_r  <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end

                default: begin
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master with a small apb_ram-style completer:
// 8 words at byte addresses 0x00..0x1F, any address >= 0x20 answers with
// pslverr. The completer mode selects zero-wait, pready stuck low, or
// pready raised after a programmable number of wait cycles.
// ---------------------------------------------------------------------------
module tb_apb_master;
    logic pclk;
    logic presetn;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- completer model ----------------
    logic [31:0] mem [8];
    int          slave_mode;   // 0 zero-wait, 1 pready stuck low, 2 delayed
    int          wait_n;
    int          acc_cnt;
    logic        addr_err;

    assign addr_err = (bus.paddr >= 32'h20);

    // Completer handshake and read data; data is X outside a completing access.
    always_comb begin
        if (slave_mode == 0)      bus.pready = 1'b1;
        else if (slave_mode == 2) bus.pready = (acc_cnt == wait_n);
        else                      bus.pready = 1'b0;
        if (bus.psel && bus.penable && bus.pready) begin
            bus.prdata  = (!bus.pwrite && !addr_err) ? mem[bus.paddr[4:2]] : 32'h0;
            bus.pslverr = addr_err;
        end else begin
            bus.prdata  = 32'hxxxx_xxxx;
            bus.pslverr = 1'bx;
        end
    end

    // Wait-cycle counter and memory write port of the completer.
    always_ff @(posedge pclk) begin
        if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else                                         acc_cnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && !addr_err)
            mem[bus.paddr[4:2]] <= bus.pwdata;
    end

    // ---------------- checking ----------------
    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check the bus phases and the response.
    task automatic run_cmd(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input bit exp_err, input bit exp_to, input int exp_access);
        int  access;
        bit  seen;
        bit  bad_bus;
        @(negedge pclk);
        check_eq({tag, "_ready"}, bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        check_eq({tag, "_setup"}, {bus.psel, bus.penable, bus.cmd_ready}, 3'b100);
        check_eq({tag, "_paddr"}, bus.paddr, addr);
        access  = 0;
        seen    = 1'b0;
        bad_bus = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (bus.psel && bus.penable && bus.paddr == addr && bus.pwrite == wr && !bus.cmd_ready)
                access++;
            else
                bad_bus = 1'b1;
        end
        check_eq({tag, "_rsp_seen"}, seen, 1'b1);
        check_eq({tag, "_access_bus"}, bad_bus, 1'b0);
        check_eq({tag, "_access_cycles"}, access, exp_access);
        check_eq({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
        check_eq({tag, "_slverr"}, bus.rsp_slverr, exp_err);
        check_eq({tag, "_timeout"}, bus.rsp_timeout, exp_to);
        check_eq({tag, "_bus_idle"}, {bus.psel, bus.penable, bus.cmd_ready}, 3'b001);
        @(negedge pclk);
        check_eq({tag, "_pulse"}, {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b000);
        check_eq({tag, "_rdata_hold"}, bus.rsp_rdata, exp_rdata);
    endtask

    // ---------------- back-to-back tables ----------------
    logic        bb_wr   [3];
    logic [31:0] bb_addr [3];
    logic [31:0] bb_wd   [3];
    logic [31:0] bb_exp  [3];
    int          acc_cyc [3];

    initial begin
        int  bb_idx;
        int  n_rsp;
        int  n_ready;
        bit  pend;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        slave_mode    = 0;
        wait_n        = 0;
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;

        // Reset state
        #22;
        check_eq("rst_bus", {bus.psel, bus.penable, bus.pwrite}, 3'b000);
        check_eq("rst_rsp", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b000);
        check_eq("rst_paddr", bus.paddr, 32'h0);
        check_eq("rst_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_ready", bus.cmd_ready, 1'b1);
        @(negedge pclk);
        presetn = 1'b1;

        // Write then read-back, zero-wait
        run_cmd("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1);
        run_cmd("rd10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1);

        // Error responses
        run_cmd("wr40", 1'b1, 32'd40, 32'h12345678, 32'h0, 1'b1, 1'b0, 1);
        run_cmd("rd40", 1'b0, 32'd40, 32'h0, 32'h0, 1'b1, 1'b0, 1);

        // Timeout with pready stuck low, then pready on the 16th access cycle
        run_cmd("rd10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1);
        slave_mode = 1;
        run_cmd("to_rd", 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 16);
        slave_mode = 2;
        wait_n     = 15;
        run_cmd("last_rd", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 16);
        wait_n     = 2;
        run_cmd("ws_wr", 1'b1, 32'h8, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0, 3);

        // Asynchronous reset during ACCESS
        slave_mode = 1;
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h10;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check_eq("mid_access", {bus.psel, bus.penable}, 2'b11);
        #2 presetn = 1'b0;
        #1;
        check_eq("async_drop", {bus.psel, bus.penable, bus.cmd_ready}, 3'b001);
        @(negedge pclk);
        @(negedge pclk);
        presetn    = 1'b1;
        slave_mode = 0;
        @(negedge pclk);
        check_eq("rst_no_rsp", {bus.rsp_valid, bus.psel}, 2'b00);
        run_cmd("post_wr", 1'b1, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1);
        run_cmd("post_rd", 1'b0, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1);

        // Back-to-back with cmd_valid held high
        bb_wr[0] = 1'b1; bb_addr[0] = 32'h0;  bb_wd[0] = 32'h1111_1111; bb_exp[0] = 32'h0;
        bb_wr[1] = 1'b0; bb_addr[1] = 32'h0;  bb_wd[1] = 32'h0;         bb_exp[1] = 32'h1111_1111;
        bb_wr[2] = 1'b0; bb_addr[2] = 32'h8;  bb_wd[2] = 32'h0;         bb_exp[2] = 32'hA5A5_5A5A;
        for (int i = 0; i < 3; i++) acc_cyc[i] = -1;
        bb_idx  = 0;
        n_rsp   = 0;
        n_ready = 0;
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = bb_wr[0];
        bus.cmd_addr  = bb_addr[0];
        bus.cmd_wdata = bb_wd[0];
        for (int c = 0; c < 15; c++) begin
            if (c < 9 && bus.cmd_ready) n_ready++;
            pend = bus.cmd_valid && bus.cmd_ready;
            if (pend) acc_cyc[bb_idx] = c;
            @(negedge pclk);
            if (pend) begin
                bb_idx++;
                if (bb_idx < 3) begin
                    bus.cmd_write = bb_wr[bb_idx];
                    bus.cmd_addr  = bb_addr[bb_idx];
                    bus.cmd_wdata = bb_wd[bb_idx];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            if (bus.rsp_valid) begin
                if (n_rsp < 3) check_eq($sformatf("bb_rdata%0d", n_rsp), bus.rsp_rdata, bb_exp[n_rsp]);
                n_rsp++;
            end
        end
        check_eq("bb_accept0", acc_cyc[0], 0);
        check_eq("bb_accept1", acc_cyc[1], 3);
        check_eq("bb_accept2", acc_cyc[2], 6);
        check_eq("bb_rsp_count", n_rsp, 3);
        check_eq("bb_ready_cycles", n_ready, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial acc_cnt = 0;
endmodule
